// File: rtl/sram_controller_if.sv
// ---------------------------------------------------------------------------
// sram_controller_if : MEM-stage data port plus 16-bit async SRAM bus
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface sram_controller_if;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;

  modport slave (
    input  rd_en, wr_en, address, write_data, sram_dq_in,
    output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );

  modport master (
    output rd_en, wr_en, address, write_data, sram_dq_in,
    input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );
endinterface

`default_nettype wire

// File: rtl/sram_controller.sv
// ---------------------------------------------------------------------------
// sram_controller : 32-bit MEM-stage access split into two 16-bit SRAM phases
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sram_controller #(
  parameter int PHASE_CYCLES = 2,
  parameter int MEM_BASE     = 1024
) (
  input  logic                clk,
  input  logic                rst,
  sram_controller_if.slave    bus
);

  localparam int                 c_CNT_W = (PHASE_CYCLES > 2) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(PHASE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [c_CNT_W-1:0]   cnt_q, cnt_d;
  logic                 is_wr_q, is_wr_d;
  logic [31:0]          read_data_q, read_data_d;
  logic [17:0]          addr_q, addr_d;
  logic [15:0]          dq_out_q, dq_out_d;

  logic                 w_req;
  logic                 w_last;
  logic                 w_ready;
  logic                 w_we_n;
  logic                 w_oe;
  logic [31:0]          w_off;
  logic                 w_unused_off;

  assign w_req        = bus.rd_en | bus.wr_en;
  assign w_last       = (cnt_q == c_LAST);
  assign w_off        = bus.address - 32'(MEM_BASE);
  assign w_unused_off = ^{w_off[31:19], w_off[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      is_wr_q     <= 1'b0;
      read_data_q <= '0;
      addr_q      <= '0;
      dq_out_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_wr_q     <= is_wr_d;
      read_data_q <= read_data_d;
      addr_q      <= addr_d;
      dq_out_q    <= dq_out_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_wr_d     = is_wr_q;
    read_data_d = read_data_q;
    addr_d      = addr_q;
    dq_out_d    = dq_out_q;
    w_ready     = 1'b0;
    w_we_n      = 1'b1;
    w_oe        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        w_ready = ~w_req;
        if (w_req) begin
          state_d = ST_LO;
          cnt_d   = '0;
          is_wr_d = bus.wr_en;
          addr_d  = {w_off[18:2], 1'b0};
          if (bus.wr_en) dq_out_d = bus.write_data[15:0];
        end
      end
      ST_LO, ST_HI: begin
        // Strobe released on the final cycle of each phase to give address/data hold.
        w_oe   = is_wr_q;
        w_we_n = ~(is_wr_q & ~w_last);
        if (w_last) begin
          cnt_d = '0;
          if (state_q == ST_LO) begin
            state_d   = ST_HI;
            addr_d[0] = 1'b1;
            if (is_wr_q) dq_out_d = bus.write_data[31:16];
            else         read_data_d[15:0] = bus.sram_dq_in;
          end else begin
            state_d   = ST_DONE;
            addr_d[0] = 1'b0;
            if (!is_wr_q) read_data_d[31:16] = bus.sram_dq_in;
          end
        end else begin
          cnt_d = cnt_q + c_ONE;
        end
      end
      ST_DONE: begin
        w_ready = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.ready       = w_ready;
  assign bus.read_data   = read_data_q;
  assign bus.sram_addr   = addr_q;
  assign bus.sram_dq_out = dq_out_q;
  assign bus.sram_dq_oe  = w_oe;
  assign bus.sram_we_n   = w_we_n;

endmodule

`default_nettype wire

// File: tb/tb_sram_controller.sv
// ---------------------------------------------------------------------------
// tb_sram_controller : randomized bench with half-word SRAM and word-level reference
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sram_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;

  sram_controller_if bus();

  sram_controller #(.PHASE_CYCLES(2), .MEM_BASE(1024)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Chip-like SRAM: captures the bus while the strobe is low.
  logic [15:0] sram [0:255] = '{default: 16'h0000};
  assign bus.sram_dq_in = sram[bus.sram_addr[7:0]];
  always @(posedge clk)
    if (bus.sram_we_n === 1'b0 && bus.sram_dq_oe === 1'b1)
      sram[bus.sram_addr[7:0]] <= bus.sram_dq_out;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] ref_mem [int];
  logic [31:0] exp_rd = 32'h0;
  logic [17:0] tr_a [$];
  logic [15:0] tr_d [$];
  int          low_n, oe_n, done_cyc;
  logic [31:0] rdata;

  function automatic int word_key(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'd1024;
    return int'((off / 4) % 131072);
  endfunction

  function automatic logic [17:0] exp_ha(input logic [31:0] a, input int hi);
    return 18'(word_key(a) * 2 + hi);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(word_key(a)) ? ref_mem[word_key(a)] : 32'h0;
  endfunction

  task automatic idle_cycles(input int n);
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Drives one access and observes it until the DONE cycle (ready back high).
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    bit got;
    bus.rd_en = rd; bus.wr_en = wr; bus.address = a; bus.write_data = d;
    tr_a.delete(); tr_d.delete();
    low_n = 0; oe_n = 0; got = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (bus.ready === 1'b0) low_n++;
      if (bus.sram_dq_oe === 1'b1) oe_n++;
      if (bus.sram_we_n === 1'b0) begin
        tr_a.push_back(bus.sram_addr);
        tr_d.push_back(bus.sram_dq_out);
      end
      if (bus.ready === 1'b1 && low_n > 0) begin
        got = 1; done_cyc = cyc; rdata = bus.read_data;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL access_timeout addr=%h: ready never returned high", a);
    end
  endtask

  task automatic test_reset;
    bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.address = 32'h0; bus.write_data = 32'h0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus.ready); end
    checks++; if (bus.sram_we_n !== 1'b1) begin errors++; $display("FAIL reset_we_n got=%b exp=1", bus.sram_we_n); end
    checks++; if (bus.sram_dq_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got=%b exp=0", bus.sram_dq_oe); end
    checks++; if (bus.sram_dq_out !== 16'h0) begin errors++; $display("FAIL reset_dq_out got=%h exp=0", bus.sram_dq_out); end
    checks++; if (bus.sram_addr !== 18'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", bus.sram_addr); end
    checks++; if (bus.read_data !== 32'h0) begin errors++; $display("FAIL reset_read_data got=%h exp=0", bus.read_data); end
    @(negedge clk);
  endtask

  task automatic test_idle;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (bus.ready !== 1'b1 || bus.sram_we_n !== 1'b1 || bus.sram_dq_oe !== 1'b0) begin
        errors++;
        $display("FAIL idle_cycle%0d ready/we_n/oe got=%b%b%b exp=110", i, bus.ready, bus.sram_we_n, bus.sram_dq_oe);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_write(input logic [31:0] a, input logic [31:0] d, input logic rd_too);
    run_access(rd_too, 1'b1, a, d);
    ref_mem[word_key(a)] = d;
    checks++; if (low_n != 5) begin errors++; $display("FAIL wr_ready_low addr=%h got=%0d exp=5", a, low_n); end
    checks++; if (oe_n != 4) begin errors++; $display("FAIL wr_oe_cycles addr=%h got=%0d exp=4", a, oe_n); end
    checks++;
    if (tr_a.size() != 2 || tr_a[0] !== exp_ha(a, 0) || tr_d[0] !== d[15:0]
        || tr_a[1] !== exp_ha(a, 1) || tr_d[1] !== d[31:16]) begin
      errors++;
      $display("FAIL wr_bus addr=%h strobes=%0d got=%h:%h,%h:%h exp=%h:%h,%h:%h", a, tr_a.size(),
               tr_a.size() > 0 ? tr_a[0] : 18'h0, tr_d.size() > 0 ? tr_d[0] : 16'h0,
               tr_a.size() > 1 ? tr_a[1] : 18'h0, tr_d.size() > 1 ? tr_d[1] : 16'h0,
               exp_ha(a, 0), d[15:0], exp_ha(a, 1), d[31:16]);
    end
    checks++; if (rdata !== exp_rd) begin errors++; $display("FAIL wr_read_data_kept got=%h exp=%h", rdata, exp_rd); end
  endtask

  task automatic test_read(input logic [31:0] a);
    run_access(1'b1, 1'b0, a, $urandom);
    exp_rd = ref_rd(a);
    checks++; if (low_n != 5) begin errors++; $display("FAIL rd_ready_low addr=%h got=%0d exp=5", a, low_n); end
    checks++; if (oe_n != 0 || tr_a.size() != 0) begin
      errors++; $display("FAIL rd_bus_quiet addr=%h oe_cycles=%0d strobes=%0d exp=0,0", a, oe_n, tr_a.size()); end
    checks++; if (rdata !== exp_rd) begin errors++; $display("FAIL rd_data addr=%h got=%h exp=%h", a, rdata, exp_rd); end
  endtask

  task automatic test_back_to_back;
    int d0, d1;
    test_write(32'd1028, 32'h1234_5678, 1'b0);
    d0 = done_cyc;
    test_read(32'd1024);
    d1 = done_cyc;
    checks++; if (d1 - d0 != 6) begin errors++; $display("FAIL b2b_gap1 got=%0d exp=6", d1 - d0); end
    test_read(32'd1028);
    checks++; if (done_cyc - d1 != 6) begin errors++; $display("FAIL b2b_gap2 got=%0d exp=6", done_cyc - d1); end
    idle_cycles(2);
  endtask

  task automatic test_rst_abort;
    bus.rd_en = 1'b1; bus.wr_en = 1'b0; bus.address = 32'd1024;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (bus.read_data !== 32'h0) begin errors++; $display("FAIL abort_read_data got=%h exp=0", bus.read_data); end
    checks++; if (bus.sram_we_n !== 1'b1 || bus.sram_dq_oe !== 1'b0) begin
      errors++; $display("FAIL abort_bus we_n/oe got=%b%b exp=10", bus.sram_we_n, bus.sram_dq_oe); end
    rst = 1'b0;
    exp_rd = 32'h0;
    test_read(32'd1024);
    idle_cycles(2);
  endtask

  task automatic test_random;
    logic [31:0] a;
    for (int i = 0; i < 24; i++) begin
      a = 32'd1024 + 32'(4 * $urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) test_write(a, $urandom, 1'($urandom_range(0, 1)));
      else                           test_read(a);
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3));
    end
    idle_cycles(2);
  endtask

  initial begin
    test_reset();
    test_idle();
    test_write(32'd1024, 32'hDEAD_BEEF, 1'b0);
    idle_cycles(2);
    test_read(32'd1024);
    idle_cycles(2);
    test_back_to_back();
    test_write(32'd1032, 32'hA5A5_5A5A, 1'b1);
    idle_cycles(2);
    test_write(32'd1020, 32'hCAFE_F00D, 1'b0);
    test_read(32'd1020);
    idle_cycles(2);
    test_rst_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
